// File: rtl/trng_ctrl.sv
// trng_ctrl
//   Sequencing controller for the ring-oscillator TRNG array. It powers the
//   oscillators and waits out a fixed warm-up time. It then samples the raw
//   oscillator bit at a programmable rate and packs the samples into
//   WIDTH-bit words. Each finished word is offered over a valid/ready
//   handshake. A repetition-count health test shuts the oscillators down and
//   raises a sticky fault when the raw stream gets stuck.
//
// Ports
//   clk         system / sampling clock (only clock)
//   reset       synchronous, active-high reset
//   enable_i    software enable, level-sensitive
//   trng_en_o   registered power enable to the oscillator array
//   trng_out_i  raw TRNG bit, asynchronous to clk
//   data_o      output word (first sample of a word lands in the MSB)
//   valid_o     data_o holds an unconsumed word
//   ready_i     consumer accepts the word
//   error_o     health-test fault, sticky until enable_i drops

module trng_ctrl #(
  parameter int WIDTH         = 32,
  parameter int WARMUP_CYCLES = 256,
  parameter int SAMPLE_DIV    = 4,
  parameter int REP_LIMIT     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable_i,
  output logic             trng_en_o,
  input  logic             trng_out_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             error_o
);

  localparam int WARM_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int BIT_W  = $clog2(WIDTH);
  localparam int REP_W  = $clog2(REP_LIMIT + 1);

  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_CYCLES - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);
  localparam logic [REP_W-1:0]  REP_MAX   = REP_W'(REP_LIMIT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_COLLECT,
    ST_HOLD,
    ST_FAULT
  } state_t;

  state_t             state_q, state_d;
  logic               sync1_q, sync1_d;
  logic               sync2_q, sync2_d;
  logic [WARM_W-1:0]  warm_cnt_q, warm_cnt_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [REP_W-1:0]   rep_q, rep_d;
  logic               prev_q, prev_d;
  logic               full_q, full_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               valid_q, valid_d;
  logic               trng_en_q, trng_en_d;
  logic               error_q, error_d;
  logic               hold_now;

  // full_q marks the cycle after a word's last strobe. The word is handed to
  // data_o (or parked in HOLD) on that cycle. rep_q == 0 means "no previous
  // sample yet", so the first strobe after warm-up starts the run at 1.
  always_comb begin
    state_d    = state_q;
    sync1_d    = trng_out_i;
    sync2_d    = sync1_q;
    warm_cnt_d = warm_cnt_q;
    div_cnt_d  = div_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    rep_d      = rep_q;
    prev_d     = prev_q;
    full_d     = full_q;
    shreg_d    = shreg_q;
    data_d     = data_q;
    valid_d    = valid_q;
    trng_en_d  = trng_en_q;
    error_d    = error_q;
    hold_now   = 1'b0;

    if (!enable_i && (state_q == ST_WARMUP || state_q == ST_COLLECT ||
                      state_q == ST_HOLD)) begin
      // Dropping the enable discards everything, including a pending word.
      state_d    = ST_IDLE;
      trng_en_d  = 1'b0;
      valid_d    = 1'b0;
      warm_cnt_d = '0;
      div_cnt_d  = '0;
      bit_cnt_d  = '0;
      rep_d      = '0;
      prev_d     = 1'b0;
      full_d     = 1'b0;
      shreg_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable_i) begin
            state_d    = ST_WARMUP;
            trng_en_d  = 1'b1;
            warm_cnt_d = '0;
          end
        end

        ST_WARMUP: begin
          if (warm_cnt_q == WARM_LAST) begin
            state_d    = ST_COLLECT;
            warm_cnt_d = '0;
            div_cnt_d  = '0;
            bit_cnt_d  = '0;
            rep_d      = '0;
            full_d     = 1'b0;
            shreg_d    = '0;
          end else begin
            warm_cnt_d = warm_cnt_q + WARM_W'(1);
          end
        end

        ST_COLLECT: begin
          if (rep_q == REP_MAX) begin
            // The fault outranks a word finished on the same strobe.
            state_d   = ST_FAULT;
            trng_en_d = 1'b0;
            valid_d   = 1'b0;
            error_d   = 1'b1;
            div_cnt_d = '0;
            bit_cnt_d = '0;
            rep_d     = '0;
            prev_d    = 1'b0;
            full_d    = 1'b0;
            shreg_d   = '0;
          end else begin
            if (valid_q && ready_i) begin
              valid_d = 1'b0;
            end
            if (full_q) begin
              full_d = 1'b0;
              if (!valid_q || ready_i) begin
                data_d  = shreg_q;
                valid_d = 1'b1;
              end else begin
                state_d  = ST_HOLD;
                hold_now = 1'b1;
              end
            end
            // Sampling stops on the very cycle HOLD is entered so the parked
            // word in shreg is not disturbed (matters when SAMPLE_DIV is 1).
            if (!hold_now) begin
              if (div_cnt_q == DIV_LAST) begin
                div_cnt_d = '0;
                shreg_d   = {shreg_q[WIDTH-2:0], sync2_q};
                prev_d    = sync2_q;
                if (rep_q != '0 && sync2_q == prev_q) begin
                  rep_d = rep_q + REP_W'(1);
                end else begin
                  rep_d = REP_W'(1);
                end
                if (bit_cnt_q == BIT_LAST) begin
                  bit_cnt_d = '0;
                  full_d    = 1'b1;
                end else begin
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
                end
              end else begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
              end
            end
          end
        end

        ST_HOLD: begin
          // valid_o is always set here, so ready_i alone means a transfer.
          if (ready_i) begin
            data_d    = shreg_q;
            state_d   = ST_COLLECT;
            div_cnt_d = '0;
          end
        end

        ST_FAULT: begin
          if (!enable_i) begin
            state_d = ST_IDLE;
            error_d = 1'b0;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      warm_cnt_q <= '0;
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      rep_q      <= '0;
      prev_q     <= 1'b0;
      full_q     <= 1'b0;
      shreg_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      trng_en_q  <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      warm_cnt_q <= warm_cnt_d;
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      rep_q      <= rep_d;
      prev_q     <= prev_d;
      full_q     <= full_d;
      shreg_q    <= shreg_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      trng_en_q  <= trng_en_d;
      error_q    <= error_d;
    end
  end

  assign trng_en_o = trng_en_q;
  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign error_o   = error_q;

endmodule

// File: tb/tb_trng_ctrl.sv
// tb_trng_ctrl
//   Self-checking bench for trng_ctrl with WIDTH=8, WARMUP_CYCLES=16,
//   SAMPLE_DIV=2, REP_LIMIT=8. A behavioural model tracks the expected
//   outputs every cycle. Directed scenarios add hand-computed literal checks.
//   A randomized phase then exercises handshakes, disables, faults and a
//   mid-run reset.

module tb_trng_ctrl;

  localparam int WIDTH = 8;
  localparam int WARM  = 16;
  localparam int DIV   = 2;
  localparam int REP   = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable_i;
  logic             trng_en_o;
  logic             trng_out_i;
  logic [WIDTH-1:0] data_o;
  logic             valid_o;
  logic             ready_i;
  logic             error_o;

  trng_ctrl #(
    .WIDTH(WIDTH),
    .WARMUP_CYCLES(WARM),
    .SAMPLE_DIV(DIV),
    .REP_LIMIT(REP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable_i(enable_i),
    .trng_en_o(trng_en_o),
    .trng_out_i(trng_out_i),
    .data_o(data_o),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .error_o(error_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
    end
  endtask

  // Behavioural model: modes, elapsed-cycle counts, an integer word built
  // arithmetically and a run-length counter for the health test.
  localparam int M_IDLE  = 0;
  localparam int M_WARM  = 1;
  localparam int M_COLL  = 2;
  localparam int M_HOLD  = 3;
  localparam int M_FAULT = 4;

  int  m_mode = M_IDLE;
  int  m_elapsed, m_coll, m_nbits, m_run, m_last;
  int  m_t1, m_t2;
  int  m_word, m_done_word, m_held;
  bit  m_done;
  bit  m_in_reset;
  bit  model_live = 1'b0;
  bit  exp_en, exp_valid, exp_err;
  int  exp_data;

  task automatic modelIdle();
    m_mode    = M_IDLE;
    exp_valid = 1'b0;
    m_done    = 1'b0;
    m_nbits   = 0;
    m_run     = 0;
  endtask

  always @(posedge clk) begin
    int s;
    bit old_valid;
    bit frozen;
    if (reset) begin
      model_live = 1'b1;
      m_in_reset = 1'b1;
      m_mode     = M_IDLE;
      m_t1       = 0;
      m_t2       = 0;
      m_done     = 1'b0;
      m_nbits    = 0;
      m_run      = 0;
      m_word     = 0;
      exp_valid  = 1'b0;
      exp_err    = 1'b0;
      exp_data   = 0;
      exp_en     = 1'b0;
    end else begin
      m_in_reset = 1'b0;
      // s seen at this edge is the raw bit captured two edges ago.
      s    = m_t2;
      m_t2 = m_t1;
      m_t1 = int'(trng_out_i);
      old_valid = exp_valid;
      frozen    = 1'b0;
      case (m_mode)
        M_IDLE: begin
          if (enable_i) begin
            m_mode    = M_WARM;
            m_elapsed = 0;
          end
        end
        M_WARM: begin
          if (!enable_i) modelIdle();
          else begin
            m_elapsed++;
            if (m_elapsed == WARM) begin
              m_mode  = M_COLL;
              m_coll  = 0;
              m_nbits = 0;
              m_run   = 0;
              m_done  = 1'b0;
            end
          end
        end
        M_COLL: begin
          if (!enable_i) modelIdle();
          else if (m_run >= REP) begin
            m_mode    = M_FAULT;
            exp_valid = 1'b0;
            exp_err   = 1'b1;
            m_done    = 1'b0;
            m_nbits   = 0;
            m_run     = 0;
          end else begin
            if (old_valid && ready_i) exp_valid = 1'b0;
            if (m_done) begin
              m_done = 1'b0;
              if (!old_valid || ready_i) begin
                exp_data  = m_done_word;
                exp_valid = 1'b1;
              end else begin
                m_mode = M_HOLD;
                m_held = m_done_word;
                frozen = 1'b1;
              end
            end
            if (!frozen) begin
              m_coll++;
              if (m_coll % DIV == 0) begin
                m_word = (m_word * 2 + s) % (1 << WIDTH);
                m_nbits++;
                m_run  = (m_run > 0 && s == m_last) ? m_run + 1 : 1;
                m_last = s;
                if (m_nbits == WIDTH) begin
                  m_done      = 1'b1;
                  m_done_word = m_word;
                  m_nbits     = 0;
                end
              end
            end
          end
        end
        M_HOLD: begin
          if (!enable_i) modelIdle();
          else if (ready_i) begin
            exp_data = m_held;
            m_mode   = M_COLL;
            m_coll   = 0;
          end
        end
        M_FAULT: begin
          if (!enable_i) begin
            m_mode  = M_IDLE;
            exp_err = 1'b0;
          end
        end
        default: m_mode = M_IDLE;
      endcase
      exp_en = (m_mode == M_WARM) || (m_mode == M_COLL) || (m_mode == M_HOLD);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_live) begin
      checkOutput("model_trng_en", int'(trng_en_o), int'(exp_en));
      checkOutput("model_valid", int'(valid_o), int'(exp_valid));
      checkOutput("model_error", int'(error_o), int'(exp_err));
      if (exp_valid || m_in_reset) begin
        checkOutput("model_data", int'(data_o), exp_data);
      end
    end
  end

  // Directed stimulus: rel_k counts edges since the enabling edge E0.
  int        rel_k;
  bit [15:0] pat   = 16'hAAAA;
  bit        stuck = 1'b0;

  function automatic logic trngFor(input int k);
    if (stuck) return 1'b1;
    if (k >= 16 && k <= 46 && (k % 2) == 0) return pat[15 - ((k - 16) / 2)];
    return ((k / 2) % 2) == 0;
  endfunction

  task automatic step();
    trng_out_i = trngFor(rel_k + 1);
    @(posedge clk);
    @(negedge clk);
    rel_k++;
  endtask

  task automatic runTo(input int k);
    while (rel_k < k) step();
  endtask

  task automatic goIdle();
    enable_i = 1'b0;
    step();
    step();
  endtask

  task automatic applyStimulus();
    enable_i = 1'b1;
    rel_k    = -1;
    step();
  endtask

  initial begin
    reset      = 1'b1;
    enable_i   = 1'b1;
    trng_out_i = 1'b0;
    ready_i    = 1'b0;

    // Reset held for 3 cycles with enable high: everything stays 0.
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("reset_trng_en", int'(trng_en_o), 0);
      checkOutput("reset_valid", int'(valid_o), 0);
      checkOutput("reset_error", int'(error_o), 0);
      checkOutput("reset_data", int'(data_o), 0);
    end
    reset = 1'b0;
    #1;
    checkOutput("post_reset_trng_en", int'(trng_en_o), 0);
    checkOutput("post_reset_valid", int'(valid_o), 0);

    // Alternating samples, consumer always ready.
    ready_i = 1'b1;
    pat     = 16'hAAAA;
    rel_k   = -1;
    step();
    checkOutput("en_after_e0", int'(trng_en_o), 1);
    runTo(32);
    checkOutput("valid_e32", int'(valid_o), 0);
    runTo(33);
    checkOutput("valid_e33", int'(valid_o), 1);
    checkOutput("data_e33", int'(data_o), 8'hAA);
    runTo(34);
    checkOutput("valid_e34_consumed", int'(valid_o), 0);
    runTo(49);
    checkOutput("valid_e49_next", int'(valid_o), 1);
    checkOutput("data_e49_next", int'(data_o), 8'hAA);

    // Back-pressure: second word parks in HOLD until a single ready pulse.
    goIdle();
    ready_i = 1'b0;
    pat     = 16'hAACC;
    applyStimulus();
    runTo(33);
    checkOutput("bp_valid_e33", int'(valid_o), 1);
    checkOutput("bp_data_e33", int'(data_o), 8'hAA);
    runTo(93);
    checkOutput("bp_hold_valid", int'(valid_o), 1);
    checkOutput("bp_hold_data", int'(data_o), 8'hAA);
    checkOutput("bp_hold_trng_en", int'(trng_en_o), 1);
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    checkOutput("bp_release_valid", int'(valid_o), 1);
    checkOutput("bp_release_data", int'(data_o), 8'hCC);
    ready_i = 1'b1;
    runTo(140);

    // Stuck-at-1: word completion and rep limit coincide, the fault wins.
    goIdle();
    stuck = 1'b1;
    applyStimulus();
    runTo(32);
    checkOutput("stuck_e32_error", int'(error_o), 0);
    checkOutput("stuck_e32_trng_en", int'(trng_en_o), 1);
    runTo(33);
    checkOutput("stuck_e33_error", int'(error_o), 1);
    checkOutput("stuck_e33_trng_en", int'(trng_en_o), 0);
    checkOutput("stuck_e33_valid", int'(valid_o), 0);
    runTo(40);
    checkOutput("stuck_sticky_error", int'(error_o), 1);
    checkOutput("stuck_no_word", int'(valid_o), 0);

    // Fault exit, then full warm-up again.
    enable_i = 1'b0;
    step();
    checkOutput("fault_exit_error", int'(error_o), 0);
    checkOutput("fault_exit_trng_en", int'(trng_en_o), 0);
    stuck = 1'b0;
    pat   = 16'hAAAA;
    applyStimulus();
    runTo(32);
    checkOutput("reen_valid_e32", int'(valid_o), 0);
    runTo(33);
    checkOutput("reen_valid_e33", int'(valid_o), 1);
    checkOutput("reen_data_e33", int'(data_o), 8'hAA);

    // Disable mid-collect with a word pending.
    goIdle();
    ready_i = 1'b0;
    applyStimulus();
    runTo(42);
    checkOutput("dis_pending_valid", int'(valid_o), 1);
    enable_i = 1'b0;
    step();
    checkOutput("dis_valid", int'(valid_o), 0);
    checkOutput("dis_trng_en", int'(trng_en_o), 0);
    applyStimulus();
    runTo(32);
    checkOutput("dis_reen_valid_e32", int'(valid_o), 0);
    runTo(33);
    checkOutput("dis_reen_valid_e33", int'(valid_o), 1);
    checkOutput("dis_reen_data_e33", int'(data_o), 8'hAA);

    // Randomized phase: sticky raw bits, random ready, random disables.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 35) trng_out_i = ~trng_out_i;
      ready_i = ($urandom_range(0, 99) < 60);
      if (exp_err && $urandom_range(0, 7) == 0) enable_i = 1'b0;
      else if (!enable_i && $urandom_range(0, 3) == 0) enable_i = 1'b1;
      else if ($urandom_range(0, 299) == 0) enable_i = 1'b0;
      if (i == 1500) reset = 1'b1;
      if (i == 1502) reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
